// File: rtl/fetch_queue_if.sv
// Handshake bundle between the PC stage, instruction memory and decode for the fetch queue.
interface fetch_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    logic [DATA_WIDTH-1:0]    pc_i;
    logic                     pc_valid_i;
    logic                     pc_ready_o;
    logic                     imem_req_o;
    logic [DATA_WIDTH-1:0]    imem_addr_o;
    logic [31:0]              imem_rdata_i;
    logic                     flush_i;
    logic                     id_valid_o;
    logic                     id_ready_i;
    logic [31:0]              id_instr_o;
    logic [DATA_WIDTH-1:0]    id_pc_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  pc_i, pc_valid_i, imem_rdata_i, flush_i, id_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, count_o
    );

    modport master (
        output pc_i, pc_valid_i, imem_rdata_i, flush_i, id_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one imem read per accepted PC, buffers {instr, pc} pairs
// for decode, and uses credit counting so a returning response always has a free slot.
module fetch_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]           instr;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] pc_q;

    logic [CW:0]           credit_c;
    logic                  ready_c;
    logic                  accept_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  valid_c;

    // Handshake control: queued entries plus the outstanding read must fit in DEPTH.
    always_comb begin
        credit_c = (CW+1)'(count) + (CW+1)'(inflight);
        ready_c  = rst & ~bus.flush_i & (credit_c < (CW+1)'(DEPTH));
        accept_c = bus.pc_valid_i & ready_c;
        valid_c  = (count != '0);
        push_c   = inflight & ~bus.flush_i;
        pop_c    = valid_c & bus.id_ready_i & ~bus.flush_i;
    end

    // Output decode toward imem and decode; the empty queue presents a NOP at PC 0.
    always_comb begin
        bus.pc_ready_o  = ready_c;
        bus.imem_req_o  = accept_c;
        bus.imem_addr_o = bus.pc_i;
        bus.id_valid_o  = valid_c;
        bus.id_instr_o  = NOP;
        bus.id_pc_o     = '0;
        bus.count_o     = count;
        if (valid_c) begin
            bus.id_instr_o = mem[rptr].instr;
            bus.id_pc_o    = mem[rptr].pc;
        end
    end

    // Control state; flush clears everything and kills the outstanding read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            pc_q     <= '0;
        end else if (bus.flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept_c;
            if (accept_c) pc_q <= bus.pc_i;
            if (push_c)   wptr <= wptr + PW'(1);
            if (pop_c)    rptr <= rptr + PW'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push_c) mem[wptr] <= {bus.imem_rdata_i, pc_q};
    end
endmodule
